// File: rtl/sha256_wk_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha256_wk_scheduler                                           |
// | Purpose  : Expands one 512-bit message block into the SHA-256 message    |
// |            schedule and streams W[t] + K[t] to the round stage, one      |
// |            word per accepted round. Only a 16-word sliding window of     |
// |            the schedule is held.                                         |
// | Ports    : clk, rst_n            - clock, async active-low reset         |
// |            blk_valid/blk_ready   - block handshake                       |
// |            blk_data[511:0]       - block, word 0 in bits [511:480]       |
// |            wk_valid/wk_ready     - round-output handshake                |
// |            wk[31:0], round[5:0]  - pre-added W+K and its round index     |
// |            last                  - current wk is round 63                |
// |            done                  - one-cycle pulse after round 63 taken  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sha256_wk_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         wk_valid,
  input  logic         wk_ready,
  output logic [31:0]  wk,
  output logic [5:0]   round,
  output logic         last,
  output logic         done
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  logic [0:0]  state_q, state_d;
  logic [5:0]  round_q, round_d;
  logic        done_q,  done_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] w_new;

  // w_q[0] is always W[round]; the next word needed is W[round+16].
  assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    w_d     = w_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = blk_data[511 - 32*i -: 32];
          end
          round_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_IDLE;
            round_d = '0;
            done_d  = 1'b1;
          end else begin
            for (int i = 0; i < 15; i++) begin
              w_d[i] = w_q[i+1];
            end
            w_d[15] = w_new;
            round_d = round_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end

  // All outputs decode from registered state only.
  assign blk_ready = (state_q == ST_IDLE);
  assign wk_valid  = (state_q == ST_RUN);
  assign round     = round_q;
  assign last      = (state_q == ST_RUN) && (round_q == LAST_ROUND);
  assign done      = done_q;
  assign wk        = w_q[0] + K_ROM[round_q];

endmodule
`default_nettype wire

// File: tb/tb_sha256_wk_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sha256_wk_scheduler                                        |
// | Purpose  : Self-checking bench for sha256_wk_scheduler. Stimulus pushes  |
// |            expected (round, wk, last) entries into a scoreboard queue;  |
// |            a monitor pops and compares on every wk handshake.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sha256_wk_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         wk_valid;
  logic         wk_ready;
  logic [31:0]  wk;
  logic [5:0]   round;
  logic         last;
  logic         done;

  always #5 clk = ~clk;

  sha256_wk_scheduler #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .wk_valid  (wk_valid),
    .wk_ready  (wk_ready),
    .wk        (wk),
    .round     (round),
    .last      (last),
    .done      (done)
  );

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] BLK_ONES = {512{1'b1}};

  typedef struct {
    logic [5:0]  rnd;
    logic [31:0] wk;
    logic        last;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full 64-word schedule reference, then push the expected output stream.
  task automatic push_block(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t        e;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.rnd  = 6'(t);
      e.wk   = w[t] + K_TB[t];
      e.last = (t == 63);
      sb.push_back(e);
    end
  endtask

  // Monitor: compare on every accepted wk.
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && wk_valid && wk_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wk: got round=%0d wk=0x%08h expected no output", round, wk);
      end else begin
        m_e = sb.pop_front();
        check("sb_wk",    wk,              m_e.wk);
        check("sb_round", {26'b0, round},  {26'b0, m_e.rnd});
        check("sb_last",  {31'b0, last},   {31'b0, m_e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"}, {31'b0, blk_ready}, 32'd1);
    check({tag, "_wk_valid"},  {31'b0, wk_valid},  32'd0);
    check({tag, "_wk"},        wk,                 32'h428a2f98);
    check({tag, "_round"},     {26'b0, round},     32'd0);
    check({tag, "_last"},      {31'b0, last},      32'd0);
    check({tag, "_done"},      {31'b0, done},      32'd0);
  endtask

  // Runs one block from IDLE to done. stall: 5-cycle hold at round 16 and
  // 1-cycle hold at round 63. hand: check abc hand-computed rounds.
  // offer: present another block at rounds 10..11 while running.
  task automatic run_block(input logic [511:0] blk, input bit stall, input bit hand, input bit offer);
    int first, dcyc, hold;
    bit seen16, seen63;
    first = -1; dcyc = -1; hold = 0; seen16 = 0; seen63 = 0;
    blk_data  = blk;
    blk_valid = 1'b1;
    push_block(blk);
    for (int n = 0; n < 300 && dcyc < 0; n++) begin
      tick();
      if (wk_valid && first < 0) begin
        first     = cyc;
        blk_valid = 1'b0;
      end
      if (hold > 0) begin
        if (seen63) begin
          check("stall63_round", {26'b0, round}, 32'd63);
        end else begin
          check("stall16_round", {26'b0, round}, 32'd16);
          check("stall16_wk",    wk,             32'h45FDCD41);
        end
        hold--;
        if (hold == 0) wk_ready = 1'b1;
      end else if (stall && wk_valid && round == 6'd16 && !seen16) begin
        seen16 = 1; wk_ready = 1'b0; hold = 5;
      end else if (stall && wk_valid && round == 6'd63 && !seen63) begin
        seen63 = 1; wk_ready = 1'b0; hold = 1;
      end
      if (hand && wk_valid) begin
        case (round)
          6'd0:  check("abc_r0",  wk, 32'hA3EC9318);
          6'd15: check("abc_r15", wk, 32'hC19BF18C);
          6'd16: check("abc_r16", wk, 32'h45FDCD41);
          6'd17: check("abc_r17", wk, 32'hEFCD4786);
          default: ;
        endcase
      end
      if (offer && wk_valid && (round == 6'd10 || round == 6'd11)) begin
        blk_data  = BLK_ONES;
        blk_valid = 1'b1;
        check("offer_blk_ready", {31'b0, blk_ready}, 32'd0);
      end else if (offer && first >= 0) begin
        blk_valid = 1'b0;
      end
      if (done) begin
        dcyc = cyc;
        check("ready_on_done", {31'b0, blk_ready}, 32'd1);
      end
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end else begin
      check("done_latency", 32'(dcyc - first), stall ? 32'd70 : 32'd64);
    end
    tick();
    check("done_width",    {31'b0, done},     32'd0);
    check("idle_after",    {31'b0, wk_valid}, 32'd0);
  endtask

  task automatic run_back_to_back();
    int first, dcyc;
    first = -1; dcyc = -1;
    blk_data  = BLK_ABC;
    blk_valid = 1'b1;
    push_block(BLK_ABC);
    for (int n = 0; n < 300 && dcyc < 0; n++) begin
      tick();
      if (wk_valid && first < 0) begin
        first    = cyc;
        blk_data = BLK_ONES;
        push_block(BLK_ONES);
      end
      if (done) dcyc = cyc;
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL b2b_timeout: got no done expected done within 300 cycles");
    end else begin
      check("b2b_done_latency", 32'(dcyc - first), 32'd64);
      check("b2b_ready_on_done", {31'b0, blk_ready}, 32'd1);
    end
    tick();
    blk_valid = 1'b0;
    check("b2b_second_valid", {31'b0, wk_valid}, 32'd1);
    check("b2b_second_round", {26'b0, round},    32'd0);
    check("b2b_second_r0",    wk,                32'h428A2F97);
    first = cyc; dcyc = -1;
    for (int n = 0; n < 300 && dcyc < 0; n++) begin
      tick();
      if (done) dcyc = cyc;
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL b2b2_timeout: got no done expected done within 300 cycles");
    end else begin
      check("b2b2_done_latency", 32'(dcyc - first), 32'd64);
    end
    tick();
  endtask

  task automatic run_mid_reset();
    bit hit;
    hit = 0;
    blk_data  = BLK_ABC;
    blk_valid = 1'b1;
    push_block(BLK_ABC);
    for (int n = 0; n < 100 && !hit; n++) begin
      tick();
      if (wk_valid) blk_valid = 1'b0;
      if (wk_valid && round == 6'd20) hit = 1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL rst_round20_timeout: got no round 20 expected round 20 within 100 cycles");
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_outputs("midrst");
    for (int n = 0; n < 3; n++) begin
      tick();
      check("midrst_hold_done", {31'b0, done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("midrst_rel_done",      {31'b0, done},      32'd0);
      check("midrst_rel_blk_ready", {31'b0, blk_ready}, 32'd1);
      check("midrst_rel_wk_valid",  {31'b0, wk_valid},  32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b1;
    blk_data  = BLK_ONES;
    wk_ready  = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n     = 1'b1;
    blk_valid = 1'b0;
    tick();
    tick();
    check_reset_outputs("idle");

    run_block(BLK_ABC, 1'b0, 1'b1, 1'b0);
    run_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    run_back_to_back();
    run_block(BLK_ABC, 1'b0, 1'b0, 1'b1);
    run_mid_reset();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
